// File: rtl/uart_boot_loader_if.sv
// Signal bundle between the UART receiver, the boot loader, instruction memory and the core.
// The loader uses the slave view; the environment driving UART bytes uses the master view.
interface uart_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        boot_done;
    logic        boot_error;

    modport master (
        output rx_data,
        output rx_valid,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_hold,
        input  boot_done,
        input  boot_error
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_hold,
        output boot_done,
        output boot_error
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over UART, writes it word by word into instruction memory
// and releases the core only after the payload checksum matches.
module uart_boot_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_WORDS      = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic               clk,
    input logic               rst,
    uart_boot_loader_if.slave bus_io
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       num_words_q, num_words_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        chk_q, chk_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              imem_we_q, imem_we_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_error_q, boot_error_d;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [15:0]       len_w;
    logic              timer_active;
    logic              is_sync;

    assign rx_valid     = bus_io.rx_valid;
    assign rx_data      = bus_io.rx_data;
    assign len_w        = {rx_data, len_lo_q};
    assign is_sync      = rx_valid && (rx_data == SYNC_BYTE);
    assign timer_active = (state_q == StLenLo) || (state_q == StLenHi) ||
                          (state_q == StData)  || (state_q == StCheck);

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        num_words_d  = num_words_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        chk_d        = chk_q;
        tmo_d        = tmo_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (timer_active) begin
            tmo_d = rx_valid ? '0 : tmo_q + TmoW'(1);
        end

        unique case (state_q)
            StIdle, StError: begin
                // A sync byte starts a fresh frame; in StError it also retires the error.
                if (is_sync) begin
                    state_d    = StLenLo;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    chk_d      = '0;
                    tmo_d      = '0;
                end
            end
            StLenLo: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (rx_valid) begin
                    num_words_d = len_w;
                    if (len_w > 16'(MAX_WORDS)) begin
                        state_d = StError;
                    end else if (len_w == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (rx_valid) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    chk_d      = chk_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Write is registered, so it overlaps reception of the next word.
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {rx_data, asm_q[23:0]};
                        imem_addr_d  = {14'd0, word_idx_q, 2'b00};
                        word_idx_d   = word_idx_q + 16'd1;
                        if (word_idx_q == num_words_q - 16'd1) begin
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (rx_valid) begin
                    state_d = (rx_data == chk_q) ? StDone : StError;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        if (timer_active && (tmo_d == TmoW'(TIMEOUT_CYCLES))) begin
            state_d = StError;
        end

        boot_done_d  = (state_d == StDone);
        boot_error_d = (state_d == StError);
        cpu_hold_d   = (state_d != StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            len_lo_q     <= '0;
            num_words_q  <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            chk_q        <= '0;
            tmo_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            boot_done_q  <= 1'b0;
            boot_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            num_words_q  <= num_words_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            chk_q        <= chk_d;
            tmo_q        <= tmo_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            boot_done_q  <= boot_done_d;
            boot_error_q <= boot_error_d;
        end
    end

    assign bus_io.imem_we    = imem_we_q;
    assign bus_io.imem_addr  = imem_addr_q;
    assign bus_io.imem_wdata = imem_wdata_q;
    assign bus_io.cpu_hold   = cpu_hold_q;
    assign bus_io.boot_done  = boot_done_q;
    assign bus_io.boot_error = boot_error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: frame-level reference model with an expected-write queue and
// expected status flags, checked every falling edge, plus directed and randomized frames.
module tb_uart_boot_loader;

    localparam int unsigned TMO  = 50;
    localparam int unsigned MAXW = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_boot_loader_if bus ();

    uart_boot_loader #(
        .SYNC_BYTE      (8'hA5),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q[$];
    logic [31:0] words[$];
    bit          exp_done = 1'b0;
    bit          exp_err  = 1'b0;
    bit          chk_en   = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    int          nwrites   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of the DUT against the frame-level model.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check32("boot_done", 32'(bus.boot_done), 32'(exp_done));
                check32("boot_error", 32'(bus.boot_error), 32'(exp_err));
                check32("cpu_hold", 32'(bus.cpu_hold), 32'(!exp_done));
                if (bus.imem_we) begin
                    nwrites++;
                    last_addr = bus.imem_addr;
                    last_data = bus.imem_wdata;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got addr %h data %h expected none",
                                 bus.imem_addr, bus.imem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check32("write_addr", bus.imem_addr, e.addr);
                        check32("write_data", bus.imem_wdata, e.data);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    function automatic int rgap(input int max_gap);
        return int'($urandom_range(max_gap, 0));
    endfunction

    // Checksum = XOR of all payload bytes = XOR of the bytes of the XOR of all words.
    function automatic logic [7:0] model_chk();
        logic [31:0] x;
        x = '0;
        foreach (words[i]) x ^= words[i];
        return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
    endfunction

    task automatic push_write(input int idx);
        wr_t e;
        e.addr = 32'(idx * 4);
        e.data = words[idx];
        exp_q.push_back(e);
    endtask

    task automatic send_word_bytes(input int idx, input int nbytes, input int max_gap);
        logic [31:0] w;
        w = words[idx];
        for (int k = 0; k < nbytes; k++) begin
            send_byte(w[8*k +: 8]);
            idle(rgap(max_gap));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit corrupt, input int max_gap);
        logic [15:0] len;
        len = 16'(n);
        send_byte(8'hA5);
        exp_err = 1'b0;
        idle(rgap(max_gap));
        send_byte(len[7:0]);
        idle(rgap(max_gap));
        send_byte(len[15:8]);
        if (n > int'(MAXW)) begin
            exp_err = 1'b1;
            idle(rgap(max_gap));
            return;
        end
        idle(rgap(max_gap));
        for (int i = 0; i < n; i++) push_write(i);
        for (int i = 0; i < n; i++) send_word_bytes(i, 4, max_gap);
        send_byte(model_chk() ^ (corrupt ? 8'hFF : 8'h00));
        exp_done = !corrupt;
        exp_err  = corrupt;
        idle(rgap(max_gap));
    endtask

    initial begin
        int n;
        int w0;
        bit corrupt;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(2);
        check32("rst_we", 32'(bus.imem_we), 32'd0);
        check32("rst_addr", bus.imem_addr, 32'd0);
        check32("rst_wdata", bus.imem_wdata, 32'd0);
        check32("rst_hold", 32'(bus.cpu_hold), 32'd1);
        check32("rst_done", 32'(bus.boot_done), 32'd0);
        check32("rst_err", 32'(bus.boot_error), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single-word image.
        words = '{32'h0000_0013};
        check32("t1_model_chk", 32'(model_chk()), 32'h13);
        run_frame(1, 1'b0, 0);
        check32("t1_addr", last_addr, 32'h0);
        check32("t1_data", last_data, 32'h0000_0013);
        check32("t1_nwr", 32'(nwrites), 32'd1);
        check32("t1_done", 32'(bus.boot_done), 32'd1);

        // Two words, back to back.
        do_reset();
        words = '{32'h1234_5678, 32'hDEAD_BEEF};
        check32("t2_model_chk", 32'(model_chk()), 32'h2A);
        run_frame(2, 1'b0, 0);
        check32("t2_addr", last_addr, 32'h4);
        check32("t2_data", last_data, 32'hDEAD_BEEF);
        check32("t2_nwr", 32'(nwrites), 32'd3);

        // Bad checksum, then recovery by resending.
        do_reset();
        run_frame(2, 1'b1, 0);
        check32("t3_err", 32'(bus.boot_error), 32'd1);
        check32("t3_hold", 32'(bus.cpu_hold), 32'd1);
        check32("t3_nwr", 32'(nwrites), 32'd5);
        run_frame(2, 1'b0, 0);
        check32("t3_done", 32'(bus.boot_done), 32'd1);
        check32("t3_err_clr", 32'(bus.boot_error), 32'd0);

        // Oversized length, then empty image.
        do_reset();
        w0 = nwrites;
        run_frame(513, 1'b0, 0);
        check32("t4_err", 32'(bus.boot_error), 32'd1);
        words = {};
        run_frame(0, 1'b0, 0);
        check32("t4_done", 32'(bus.boot_done), 32'd1);
        check32("t4_nwr", 32'(nwrites - w0), 32'd0);

        // Timeout after one word and one stray byte.
        do_reset();
        w0    = nwrites;
        words = '{32'h0A0B_0C0D, 32'h1020_3040, 32'h5060_7080, 32'h0102_0304};
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        push_write(0);
        send_word_bytes(0, 4, 0);
        send_word_bytes(1, 1, 0);
        idle(int'(TMO) - 1);
        check32("t5_no_err_early", 32'(bus.boot_error), 32'd0);
        idle(1);
        exp_err = 1'b1;
        check32("t5_err", 32'(bus.boot_error), 32'd1);
        check32("t5_nwr", 32'(nwrites - w0), 32'd1);
        idle(3);

        // Leading junk, then reset in the middle of the payload.
        do_reset();
        w0    = nwrites;
        words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'h0DDE_EFF0};
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        push_write(0);
        push_write(1);
        send_word_bytes(0, 4, 0);
        send_word_bytes(1, 4, 0);
        send_word_bytes(2, 2, 0);
        do_reset();
        check32("t6_rst_we", 32'(bus.imem_we), 32'd0);
        check32("t6_rst_addr", bus.imem_addr, 32'd0);
        check32("t6_rst_wdata", bus.imem_wdata, 32'd0);
        check32("t6_rst_hold", 32'(bus.cpu_hold), 32'd1);
        send_byte(8'hBB);
        send_byte(8'h99);
        send_word_bytes(3, 4, 0);
        send_byte(8'h3C);
        idle(3);
        check32("t6_nwr", 32'(nwrites - w0), 32'd2);
        send_byte(8'h00);
        send_byte(8'hFF);
        run_frame(4, 1'b0, 1);
        check32("t6_done", 32'(bus.boot_done), 32'd1);

        // Randomized frames.
        for (int it = 0; it < 30; it++) begin
            if (exp_done) do_reset();
            n = int'($urandom_range(8, 1));
            if ($urandom_range(9, 0) == 0) n = 0;
            if ($urandom_range(9, 0) == 1) n = int'(MAXW) + 1 + int'($urandom_range(100, 0));
            corrupt = ($urandom_range(3, 0) == 0);
            words = {};
            if (n <= int'(MAXW)) begin
                for (int i = 0; i < n; i++) words.push_back($urandom);
            end
            run_frame(n, corrupt, 3);
        end

        idle(4);
        check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
